// File: rtl/serial_tx.sv
// UART-style serial transmitter: pops one FIFO word per frame and shifts it out LSB first.
// The bit period is a fixed-point clock divisor, and the fractional part is spread over the bits by an 8-bit accumulator.
module serial_tx (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  data_size,
   input  logic [2:0]  parity,
   input  logic        stop2,
   input  logic [31:0] brd,
   input  logic        empty,
   input  logic [8:0]  rd_data,
   output logic        rd_request,
   output logic        tx,
   output logic        busy,
   output logic        tx_done
);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

   state_t      state, state_next;
   logic [24:0] cnt;
   logic [7:0]  acc;
   logic [7:0]  shreg;
   logic        par_bit, par_en, stop2_q, stop_idx;
   logic [1:0]  size_q;
   logic [23:0] int_q;
   logic [7:0]  frac_q;
   logic [2:0]  bit_idx;

   logic        bit_end, bit_start, tx_next;
   logic [23:0] cur_int;
   logic [7:0]  cur_frac, acc_base, data_mask;
   logic [8:0]  sum;
   logic [24:0] bit_len;
   logic [2:0]  last_idx;
   logic        data_xor, par_en_in, par_bit_in;

   // The start bit begins while still in LOAD, so it uses the live divisor and a cleared accumulator.
   always_comb begin
      cur_int  = (state == LOAD) ? brd[31:8] : int_q;
      cur_frac = (state == LOAD) ? brd[7:0]  : frac_q;
      acc_base = (state == LOAD) ? 8'd0      : acc;
      sum      = {1'b0, acc_base} + {1'b0, cur_frac};
      bit_len  = {1'b0, cur_int} + {24'd0, sum[8]};
      bit_end  = (cnt == 25'd0);
      last_idx = {1'b1, size_q};
   end

   always_comb begin
      data_mask  = 8'hFF;
      par_en_in  = 1'b0;
      par_bit_in = 1'b0;
      case (data_size)
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
      data_xor = ^(rd_data[7:0] & data_mask);
      case (parity)
         3'b001:  begin par_en_in = 1'b1; par_bit_in = data_xor;    end
         3'b010:  begin par_en_in = 1'b1; par_bit_in = ~data_xor;   end
         3'b011:  begin par_en_in = 1'b1; par_bit_in = 1'b1;        end
         3'b100:  begin par_en_in = 1'b1; par_bit_in = 1'b0;        end
         3'b101:  begin par_en_in = 1'b1; par_bit_in = rd_data[8];  end
         default: begin par_en_in = 1'b0; par_bit_in = 1'b0;        end
      endcase
   end

   always_comb begin
      state_next = state;
      bit_start  = 1'b0;
      tx_next    = tx;
      tx_done    = 1'b0;
      rd_request = !reset && (state == IDLE) && enable && !empty && (brd[31:8] != 24'd0);
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (rd_request) state_next = LOAD;
         end
         LOAD: begin
            state_next = START;
            bit_start  = 1'b1;
            tx_next    = 1'b0;
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
               bit_start  = 1'b1;
               tx_next    = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_start = 1'b1;
               if (bit_idx != last_idx) begin
                  tx_next = shreg[1];
               end else if (par_en) begin
                  state_next = PARITY;
                  tx_next    = par_bit;
               end else begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
               bit_start  = 1'b1;
               tx_next    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_idx) begin
                  bit_start = 1'b1;
               end else begin
                  state_next = IDLE;
                  tx_done    = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame configuration is frozen in LOAD so later register writes only affect the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         cnt     <= '0;
         acc     <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         par_en  <= 1'b0;
         stop2_q <= 1'b0;
         stop_idx <= 1'b0;
         size_q  <= '0;
         int_q   <= '0;
         frac_q  <= '0;
         bit_idx <= '0;
      end else begin
         state <= state_next;
         tx    <= tx_next;
         if (bit_start) begin
            cnt <= bit_len - 25'd1;
            acc <= sum[7:0];
         end else if (cnt != 25'd0) begin
            cnt <= cnt - 25'd1;
         end
         if (state == LOAD) begin
            shreg    <= rd_data[7:0];
            par_bit  <= par_bit_in;
            par_en   <= par_en_in;
            stop2_q  <= stop2;
            size_q   <= data_size;
            int_q    <= brd[31:8];
            frac_q   <= brd[7:0];
            bit_idx  <= '0;
            stop_idx <= 1'b0;
         end
         if (state == DATA && bit_end) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == STOP && bit_end) stop_idx <= 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: a FIFO model feeds words, and a bit-level frame model predicts tx cycle by cycle.
module tb_serial_tx;

   logic        clk = 1'b0;
   logic        reset, enable, stop2;
   logic [1:0]  data_size;
   logic [2:0]  parity;
   logic [31:0] brd;
   logic        empty;
   logic [8:0]  rd_data = '0;
   logic        rd_request, tx, busy, tx_done;

   logic [8:0]  fifo_mem [0:63];
   int          wr_ptr = 0, rd_ptr = 0, pop_count = 0, done_count = 0;
   int          asserts = 0, failures = 0, exp_pops = 0, exp_dones = 0;

   logic        exp_bit [0:15];
   int          exp_len [0:15];
   int          nbits;

   serial_tx dut (
      .clk(clk), .reset(reset), .enable(enable), .data_size(data_size),
      .parity(parity), .stop2(stop2), .brd(brd), .empty(empty),
      .rd_data(rd_data), .rd_request(rd_request), .tx(tx), .busy(busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   assign empty = (wr_ptr == rd_ptr);

   // FIFO read side: data appears the cycle after the pop, and pops and frame completions are counted.
   always @(posedge clk) begin
      if (rd_request) begin
         rd_data   <= fifo_mem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
         pop_count <= pop_count + 1;
      end
      if (tx_done) done_count <= done_count + 1;
   end

   task checkBit(input string tag, input logic obs, input logic exp);
      asserts++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task checkInt(input string tag, input int obs, input int exp);
      asserts++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task applyStimulus(input logic [1:0] sz, input logic [2:0] par, input logic s2, input logic [31:0] b);
      data_size = sz;
      parity    = par;
      stop2     = s2;
      brd       = b;
   endtask

   task pushWord(input logic [8:0] w);
      fifo_mem[wr_ptr[5:0]] = w;
      wr_ptr++;
   endtask

   task scrambleConfig();
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    (32'($urandom_range(1, 6)) << 8) | 32'($urandom_range(0, 255)));
   endtask

   // Frame model: list of line levels with their lengths, fraction spread by a running sum mod 256.
   task buildModel(input logic [8:0] word);
      int n, acc, ip, fp, ones;
      n     = 5 + int'(data_size);
      ip    = int'(brd[31:8]);
      fp    = int'(brd[7:0]);
      nbits = 0;
      ones  = 0;
      exp_bit[nbits++] = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_bit[nbits++] = word[i];
         ones += int'(word[i]);
      end
      case (parity)
         3'd1: exp_bit[nbits++] = (ones % 2 == 1);
         3'd2: exp_bit[nbits++] = (ones % 2 == 0);
         3'd3: exp_bit[nbits++] = 1'b1;
         3'd4: exp_bit[nbits++] = 1'b0;
         3'd5: exp_bit[nbits++] = word[8];
         default: ;
      endcase
      exp_bit[nbits++] = 1'b1;
      if (stop2) exp_bit[nbits++] = 1'b1;
      acc = 0;
      for (int i = 0; i < nbits; i++) begin
         acc = acc + fp;
         exp_len[i] = ip + acc / 256;
         acc = acc % 256;
      end
   endtask

   task checkOutput(input logic [8:0] word, input bit scramble, input bit drop_enable, output int waited);
      #1;
      buildModel(word);
      waited = 0;
      while (rd_request !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkBit("frame_request", rd_request, 1'b1);
      if (rd_request !== 1'b1) return;
      checkBit("idle_tx", tx, 1'b1);
      checkBit("idle_busy", busy, 1'b0);
      exp_pops++;
      @(negedge clk);
      checkBit("load_tx", tx, 1'b1);
      checkBit("load_busy", busy, 1'b1);
      checkBit("load_no_request", rd_request, 1'b0);
      if (drop_enable) enable = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         for (int k = 0; k < exp_len[i]; k++) begin
            @(negedge clk);
            if (scramble && i == 1 && k == 0) scrambleConfig();
            checkBit("bit_tx", tx, exp_bit[i]);
            checkBit("bit_busy", busy, 1'b1);
            checkBit("bit_done", tx_done, (i == nbits - 1) && (k == exp_len[i] - 1));
         end
      end
      exp_dones++;
   endtask

   initial begin
      int waited, bad, saved_done;
      logic [8:0] w;

      reset  = 1'b1;
      enable = 1'b1;
      applyStimulus(2'b11, 3'b000, 1'b0, 32'h0000_0A00);
      repeat (2) @(negedge clk);
      checkBit("reset_tx", tx, 1'b1);
      checkBit("reset_busy", busy, 1'b0);
      checkBit("reset_done", tx_done, 1'b0);
      checkBit("reset_request", rd_request, 1'b0);

      // A word waiting in the FIFO must not be popped while reset is held.
      pushWord(9'h055);
      @(negedge clk);
      checkBit("reset_hold_request", rd_request, 1'b0);
      reset = 1'b0;
      checkOutput(9'h055, 1'b0, 1'b0, waited);
      @(negedge clk);
      checkBit("post_frame_busy", busy, 1'b0);
      checkBit("post_frame_tx", tx, 1'b1);
      checkInt("single_pop", pop_count, 1);
      checkInt("single_done", done_count, 1);

      applyStimulus(2'b11, 3'b000, 1'b0, 32'h0000_0A80);
      w = 9'($urandom_range(0, 255));
      pushWord(w);
      checkOutput(w, 1'b0, 1'b0, waited);

      applyStimulus(2'b10, 3'b010, 1'b1, 32'h0000_0300);
      pushWord(9'h041);
      checkOutput(9'h041, 1'b0, 1'b0, waited);

      applyStimulus(2'b11, 3'b101, 1'b0, 32'h0000_0400);
      pushWord(9'h0A5);
      pushWord(9'h13C);
      checkOutput(9'h0A5, 1'b0, 1'b0, waited);
      checkOutput(9'h13C, 1'b0, 1'b0, waited);
      checkInt("b2b_gap", waited, 1);

      // Random frames with the configuration changed under the running frame.
      for (int f = 0; f < 6; f++) begin
         scrambleConfig();
         w = 9'($urandom_range(0, 511));
         pushWord(w);
         checkOutput(w, 1'b1, 1'b0, waited);
      end

      applyStimulus(2'b00, 3'b001, 1'b0, 32'h0000_0240);
      pushWord(9'h0F3);
      pushWord(9'h01C);
      checkOutput(9'h0F3, 1'b0, 1'b1, waited);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (rd_request !== 1'b0 || tx !== 1'b1) bad++;
      end
      checkInt("disabled_quiet", bad, 0);
      checkInt("disabled_pops", pop_count, exp_pops);
      enable = 1'b1;
      checkOutput(9'h01C, 1'b0, 1'b0, waited);

      applyStimulus(2'b11, 3'b000, 1'b0, 32'h0000_0400);
      pushWord(9'h0C3);
      #1;
      waited = 0;
      while (rd_request !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkBit("abort_request", rd_request, 1'b1);
      exp_pops++;
      saved_done = exp_dones;
      repeat (20) @(negedge clk);
      checkBit("abort_mid_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      checkBit("abort_tx", tx, 1'b1);
      checkBit("abort_busy", busy, 1'b0);
      checkBit("abort_request_low", rd_request, 1'b0);
      reset = 1'b0;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (rd_request !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) bad++;
      end
      checkInt("abort_quiet", bad, 0);
      checkInt("abort_no_done", done_count, saved_done);

      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (rd_request !== 1'b0 || tx !== 1'b1) bad++;
      end
      checkInt("empty_hold", bad, 0);

      // Integer divisor of zero must block frames even with data waiting.
      applyStimulus(2'b11, 3'b000, 1'b0, 32'h0000_00FF);
      pushWord(9'h1AA);
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (rd_request !== 1'b0 || tx !== 1'b1) bad++;
      end
      checkInt("zero_brd_hold", bad, 0);
      applyStimulus(2'b11, 3'b011, 1'b1, 32'h0000_0300);
      checkOutput(9'h1AA, 1'b0, 1'b0, waited);

      @(negedge clk);
      checkInt("total_pops", pop_count, exp_pops);
      checkInt("total_dones", done_count, exp_dones);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
